// File: rtl/lcd_pkg.sv
// Shared state encodings, command indices and default waits for the LCD power-up sequencer.
// Also provides the wait-length helper used when loading the shared timer.
package lcd_pkg;

   localparam int unsigned WAIT_W = 24;

   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_HWRST_LOW  = 3'd1;
   localparam logic [2:0] ST_HWRST_WAIT = 3'd2;
   localparam logic [2:0] ST_ISSUE      = 3'd3;
   localparam logic [2:0] ST_WAIT_DONE  = 3'd4;
   localparam logic [2:0] ST_GAP        = 3'd5;
   localparam logic [2:0] ST_DONE       = 3'd6;
   localparam logic [2:0] ST_ERROR      = 3'd7;

   typedef enum logic [2:0] {
      S_IDLE       = ST_IDLE,
      S_HWRST_LOW  = ST_HWRST_LOW,
      S_HWRST_WAIT = ST_HWRST_WAIT,
      S_ISSUE      = ST_ISSUE,
      S_WAIT_DONE  = ST_WAIT_DONE,
      S_GAP        = ST_GAP,
      S_DONE       = ST_DONE,
      S_ERROR      = ST_ERROR
   } state_t;

   localparam logic [3:0] CMD_SWRESET = 4'd0;
   localparam logic [3:0] CMD_SLPOUT  = 4'd1;
   localparam logic [3:0] CMD_RAMWR   = 4'd8;

   localparam int unsigned DEF_RESET_WAIT_CYC  = 1200000;
   localparam int unsigned DEF_SLPOUT_WAIT_CYC = 1200000;
   localparam int unsigned DEF_STEP_WAIT_CYC   = 100;
   localparam int unsigned DEF_TIMEOUT_CYC     = 65535;
`ifdef LCD_HW_RESET_EN
   localparam int unsigned DEF_HWRST_LOW_CYC   = 100;
   localparam int unsigned DEF_HWRST_WAIT_CYC  = 1200000;
`endif

   // Load value for a wait that starts counting in the cycle that triggers it;
   // waits of 0 and 1 collapse to the shortest possible wait.
   function automatic logic [WAIT_W-1:0] wait_load(input int unsigned n);
      return (n == 0) ? '0 : WAIT_W'(n - 1);
   endfunction

endpackage

// File: rtl/lcd_wait_timer.sv
// Loadable 24-bit down-counter shared by the reset, gap and timeout waits; load takes effect next cycle.
// expired is high while one or no cycles of the loaded wait remain; holds at zero until reloaded.
module lcd_wait_timer
   import lcd_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [WAIT_W-1:0] load_val,
   output logic              expired
);

   logic [WAIT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - WAIT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q <= WAIT_W'(1));

endmodule

// File: rtl/lcd_init_sequencer.sv
// Power-up scheduler: steps the SPI command executor through indices 0..NUM_STEPS-1 with panel waits and a per-step timeout.
// start->cmd_start is 1 cycle; optional panel hardware-reset pulse under LCD_HW_RESET_EN; start is ignored while busy.
module lcd_init_sequencer
   import lcd_pkg::*;
#(
   parameter int unsigned NUM_STEPS       = int'(CMD_RAMWR) + 1,
   parameter int unsigned RESET_WAIT_CYC  = DEF_RESET_WAIT_CYC,
   parameter int unsigned SLPOUT_WAIT_CYC = DEF_SLPOUT_WAIT_CYC,
   parameter int unsigned STEP_WAIT_CYC   = DEF_STEP_WAIT_CYC,
   parameter int unsigned TIMEOUT_CYC     = DEF_TIMEOUT_CYC
`ifdef LCD_HW_RESET_EN
   ,parameter int unsigned HWRST_LOW_CYC  = DEF_HWRST_LOW_CYC
   ,parameter int unsigned HWRST_WAIT_CYC = DEF_HWRST_WAIT_CYC
`endif
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       cmd_done,
   output logic       cmd_start,
   output logic [3:0] cmd_num,
   output logic       busy,
   output logic       seq_done,
   output logic       seq_error,
   output logic       pixel_grant,
   output logic       lcd_rst_n
);

   state_t            state_q, state_d;
   logic [3:0]        step_q, step_d;
   logic              tmr_load;
   logic [WAIT_W-1:0] tmr_val;
   logic              tmr_expired;
   logic              last_step;
   logic [WAIT_W-1:0] gap_load;

   lcd_wait_timer u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .expired  (tmr_expired)
   );

   assign last_step = (step_q == 4'(NUM_STEPS - 1));

   // SWRESET and SLPOUT need the long panel settle time; everything else a short gap.
   always_comb begin
      gap_load = wait_load(STEP_WAIT_CYC);
      if (step_q == CMD_SWRESET) begin
         gap_load = wait_load(RESET_WAIT_CYC);
      end else if (step_q == CMD_SLPOUT) begin
         gap_load = wait_load(SLPOUT_WAIT_CYC);
      end
   end

   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               step_d = '0;
`ifdef LCD_HW_RESET_EN
               state_d  = S_HWRST_LOW;
               tmr_load = 1'b1;
               tmr_val  = WAIT_W'(HWRST_LOW_CYC);
`else
               state_d  = S_ISSUE;
`endif
            end
         end
`ifdef LCD_HW_RESET_EN
         S_HWRST_LOW: begin
            if (tmr_expired) begin
               state_d  = S_HWRST_WAIT;
               tmr_load = 1'b1;
               tmr_val  = WAIT_W'(HWRST_WAIT_CYC);
            end
         end
         S_HWRST_WAIT: begin
            if (tmr_expired) begin
               state_d = S_ISSUE;
            end
         end
`endif
         S_ISSUE: begin
            state_d  = S_WAIT_DONE;
            tmr_load = 1'b1;
            tmr_val  = wait_load(TIMEOUT_CYC);
         end
         S_WAIT_DONE: begin
            // cmd_done is tested first so it wins a tie with the timeout.
            if (cmd_done) begin
               if (last_step) begin
                  state_d = S_DONE;
               end else begin
                  state_d  = S_GAP;
                  tmr_load = 1'b1;
                  tmr_val  = gap_load;
               end
            end else if (tmr_expired) begin
               state_d = S_ERROR;
            end
         end
         S_GAP: begin
            if (tmr_expired) begin
               step_d  = step_q + 4'd1;
               state_d = S_ISSUE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         step_q  <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
      end
   end

`ifdef LCD_HW_RESET_EN
   logic lcd_rst_n_q, lcd_rst_n_d;

   assign lcd_rst_n_d = (state_d != S_HWRST_LOW);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lcd_rst_n_q <= 1'b1;
      end else begin
         lcd_rst_n_q <= lcd_rst_n_d;
      end
   end

   assign lcd_rst_n = lcd_rst_n_q;
`else
   assign lcd_rst_n = 1'b1;
`endif

   assign cmd_start   = (state_q == S_ISSUE);
   assign cmd_num     = step_q;
   assign busy        = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR));
   assign seq_done    = (state_q == S_DONE);
   assign seq_error   = (state_q == S_ERROR);
   assign pixel_grant = seq_done;

endmodule

// File: tb/tb_lcd_init_sequencer.sv
// Directed bench for lcd_init_sequencer: executor model plus a scoreboard of expected cmd_num and start spacing.
// Optional LCD_HW_RESET_EN build also checks the panel reset pulse width and release-to-first-command spacing.
module tb_lcd_init_sequencer;

   localparam int NUM_STEPS = 3;
`ifdef LCD_HW_RESET_EN
   localparam int FIRST_GAP = 21;
   localparam int LOW_EXP   = 8;
`else
   localparam int FIRST_GAP = 1;
   localparam int LOW_EXP   = 0;
`endif

   typedef struct {
      logic [3:0] num;
      int         gap;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       exec_done;
   logic       spur_done;
   logic       cmd_done;
   logic       cmd_start;
   logic [3:0] cmd_num;
   logic       busy;
   logic       seq_done;
   logic       seq_error;
   logic       pixel_grant;
   logic       lcd_rst_n;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   ref_cyc = 0;
   int   last_start_cyc = 0;
   int   n_starts = 0;
   int   low_cnt = 0;
   int   mute_step = -1;
   int   slow_step = -1;
   int   slow_delay = 5;
   logic prev_busy = 1'b0;
   exp_t sbq[$];
   exp_t mon_e;

   assign cmd_done = exec_done | spur_done;

   lcd_init_sequencer #(
      .NUM_STEPS       (NUM_STEPS),
      .RESET_WAIT_CYC  (20),
      .SLPOUT_WAIT_CYC (10),
      .STEP_WAIT_CYC   (4),
      .TIMEOUT_CYC     (50)
`ifdef LCD_HW_RESET_EN
      ,.HWRST_LOW_CYC  (8)
      ,.HWRST_WAIT_CYC (12)
`endif
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .cmd_done    (cmd_done),
      .cmd_start   (cmd_start),
      .cmd_num     (cmd_num),
      .busy        (busy),
      .seq_done    (seq_done),
      .seq_error   (seq_error),
      .pixel_grant (pixel_grant),
      .lcd_rst_n   (lcd_rst_n)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Executor model: answers each cmd_start after a configurable delay unless muted.
   initial begin
      exec_done = 1'b0;
      forever begin
         @(negedge clk);
         if (cmd_start === 1'b1 && rst_n === 1'b1) begin
            automatic int  dly  = (int'(cmd_num) == slow_step) ? slow_delay : 5;
            automatic bit  mute = (int'(cmd_num) == mute_step);
            repeat (dly) @(negedge clk);
            if (!mute) begin
               exec_done = 1'b1;
               ref_cyc   = cyc;
               @(negedge clk);
               exec_done = 1'b0;
            end
         end
      end
   end

   // Scoreboard consumer: each cmd_start pops the next expected index and spacing.
   initial begin
      forever begin
         @(negedge clk);
         if (lcd_rst_n === 1'b0 && rst_n === 1'b1) low_cnt++;
         if (cmd_start === 1'b1) begin
            n_starts++;
            last_start_cyc = cyc;
            total++;
            assert (sbq.size() > 0) else begin
               bad++;
               $error("FAIL unexpected_cmd_start: got cmd_num %0d expected no pulse", cmd_num);
            end
            if (sbq.size() > 0) begin
               mon_e = sbq.pop_front();
               chk("cmd_num", 32'(cmd_num), 32'(mon_e.num));
               chk("start_spacing", 32'(cyc - ref_cyc), 32'(mon_e.gap));
            end
         end
      end
   end

   task automatic push_run(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.num = 4'(i);
         e.gap = (i == 0) ? FIRST_GAP : ((i == 1) ? 20 : 10);
         sbq.push_back(e);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start   = 1'b1;
      ref_cyc = cyc;
      @(negedge clk);
      start   = 1'b0;
   endtask

   task automatic wait_flag(input bit want_err, input int budget, input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         prev_busy = busy;
         @(negedge clk);
         if ((want_err ? seq_error : seq_done) === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      chk(tag, 32'(seen), 32'd1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_cmd_start"}, 32'(cmd_start), 32'd0);
      chk({tag, "_cmd_num"}, 32'(cmd_num), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_seq_done"}, 32'(seq_done), 32'd0);
      chk({tag, "_seq_error"}, 32'(seq_error), 32'd0);
      chk({tag, "_pixel_grant"}, 32'(pixel_grant), 32'd0);
      chk({tag, "_lcd_rst_n"}, 32'(lcd_rst_n), 32'd1);
   endtask

   initial begin
      int n0;
      int l0;
      rst_n     = 1'b0;
      start     = 1'b0;
      spur_done = 1'b0;

      // Reset values.
      repeat (2) @(negedge clk);
      chk_reset_outputs("rst");
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Normal run.
      push_run(NUM_STEPS);
      n0 = n_starts;
      l0 = low_cnt;
      pulse_start();
      chk("norm_busy", 32'(busy), 32'd1);
      wait_flag(1'b0, 400, "norm_done_seen");
      chk("norm_done_lat", 32'(cyc - ref_cyc), 32'd1);
      chk("norm_grant", 32'(pixel_grant), 32'd1);
      chk("norm_busy_fall", {31'd0, busy}, 32'd0);
      chk("norm_busy_prev", {31'd0, prev_busy}, 32'd1);
      chk("norm_nstarts", 32'(n_starts - n0), 32'(NUM_STEPS));
      chk("norm_lcd_rst_low", 32'(low_cnt - l0), 32'(LOW_EXP));
      chk("norm_sb_empty", 32'(sbq.size()), 32'd0);

      // Timeout on step 1.
      mute_step = 1;
      push_run(2);
      n0 = n_starts;
      pulse_start();
      chk("to_done_clr", 32'(seq_done), 32'd0);
      chk("to_grant_clr", 32'(pixel_grant), 32'd0);
      wait_flag(1'b1, 400, "to_error_seen");
      chk("to_error_lat", 32'(cyc - last_start_cyc), 32'd50);
      chk("to_cmd_num", 32'(cmd_num), 32'd1);
      chk("to_grant", 32'(pixel_grant), 32'd0);
      chk("to_busy", 32'(busy), 32'd0);
      repeat (30) @(negedge clk);
      chk("to_error_sticky", 32'(seq_error), 32'd1);
      chk("to_nstarts", 32'(n_starts - n0), 32'd2);
      mute_step = -1;

      // cmd_done on the timeout expiry cycle.
      slow_step  = 1;
      slow_delay = 49;
      push_run(NUM_STEPS);
      pulse_start();
      chk("col_error_clr", 32'(seq_error), 32'd0);
      wait_flag(1'b0, 400, "col_done_seen");
      chk("col_no_error", 32'(seq_error), 32'd0);
      chk("col_sb_empty", 32'(sbq.size()), 32'd0);
      slow_step = -1;

      // Spurious cmd_done in the step-0 gap plus a start while busy.
      push_run(NUM_STEPS);
      n0 = n_starts;
      pulse_start();
      repeat (FIRST_GAP + 8) @(negedge clk);
      start     = 1'b1;
      spur_done = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      spur_done = 1'b0;
      wait_flag(1'b0, 400, "spur_done_seen");
      chk("spur_nstarts", 32'(n_starts - n0), 32'(NUM_STEPS));
      chk("spur_sb_empty", 32'(sbq.size()), 32'd0);

      // Asynchronous reset during the step-0 gap.
      push_run(1);
      pulse_start();
      repeat (FIRST_GAP + 8) @(negedge clk);
      chk("mid_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("mid_rst");
      @(negedge clk);
      rst_n = 1'b1;
      chk("mid_sb_empty", 32'(sbq.size()), 32'd0);
      push_run(NUM_STEPS);
      n0 = n_starts;
      pulse_start();
      wait_flag(1'b0, 400, "post_rst_done_seen");
      chk("post_rst_nstarts", 32'(n_starts - n0), 32'(NUM_STEPS));
      chk("post_rst_sb_empty", 32'(sbq.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lcd_init_sequencer.md
Name: lcd_init_sequencer

Overview:
Top-level power-up scheduler for the SPI LCD command executor. It steps the executor through command indices 0..NUM_STEPS-1, one cmd_start pulse per step, and applies the panel's mandatory post-command waits (120 ms after SWRESET and SLPOUT). It runs an optional hardware-reset pulse first, supervises each step with a timeout, and hands the SPI resource to the pixel path via pixel_grant when the sequence completes.

Parameters:
NUM_STEPS, 9, number of command indices issued (0..NUM_STEPS-1); range 1..16
RESET_WAIT_CYC, 1200000, gap cycles after step 0 (SWRESET); 120 ms at 10 MHz
SLPOUT_WAIT_CYC, 1200000, gap cycles after step 1 (SLPOUT)
STEP_WAIT_CYC, 100, gap cycles after every other non-final step
TIMEOUT_CYC, 65535, maximum cycles from cmd_start to cmd_done
HWRST_LOW_CYC, 100, lcd_rst_n low time (LCD_HW_RESET_EN only)
HWRST_WAIT_CYC, 1200000, wait after lcd_rst_n release (LCD_HW_RESET_EN only)

Ports:
clk  in  1  system clock (10 MHz nominal)
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to run the sequence
cmd_done  in  1  single-cycle pulse from the executor: current command finished
cmd_start  out  1  single-cycle pulse: executor runs command cmd_num
cmd_num  out  4  command index; held stable from cmd_start until cmd_done
busy  out  1  sequence in progress
seq_done  out  1  sticky; sequence completed
seq_error  out  1  sticky; step timed out
pixel_grant  out  1  SPI owned by the pixel writer; equals seq_done
lcd_rst_n  out  1  panel hardware reset, active-low

Behaviour:
- Clock clk; reset rst_n, asynchronous, active-low. Reset values: cmd_start=0, cmd_num=0, busy=0, seq_done=0, seq_error=0, pixel_grant=0, lcd_rst_n=1; state IDLE; counters=0.
- Counters: one shared 24-bit wait counter; step index 4 bits. Counters compare against (PARAM-1), so a wait of N lasts exactly N cycles.
- States: IDLE, HWRST_LOW, HWRST_WAIT, ISSUE, WAIT_DONE, GAP, DONE, ERROR.
- IDLE/DONE/ERROR + start: clear seq_done, seq_error and pixel_grant; set busy; set step=0; go to HWRST_LOW (macro on) or ISSUE.
- start while busy=1: ignored.
- ISSUE: drive cmd_num=step and pulse cmd_start for exactly one cycle; go to WAIT_DONE; clear the counter. From start to cmd_start is 1 cycle (macro off).
- WAIT_DONE on cmd_done:
  - If step==NUM_STEPS-1: go to DONE.
  - Otherwise: go to GAP. Gap length is RESET_WAIT_CYC for step 0, SLPOUT_WAIT_CYC for step 1, and STEP_WAIT_CYC for all other steps.
- WAIT_DONE with no cmd_done after TIMEOUT_CYC cycles: go to ERROR.
- cmd_done in the same cycle as timeout expiry: cmd_done wins.
- GAP expiry: step+1, then ISSUE.
- DONE: busy=0, seq_done=1, pixel_grant=1; hold until the next start.
- ERROR: busy=0, seq_error=1, pixel_grant=0; cmd_num holds the failing step.
- cmd_done outside WAIT_DONE: ignored; it never advances the step.
- A gap of 0 is treated as 1 cycle.
- Reset mid-sequence: immediate return to reset values; any cmd_start in flight is dropped.

Optional Feature:
LCD_HW_RESET_EN
- Defined: start enters HWRST_LOW. lcd_rst_n=0 for HWRST_LOW_CYC cycles, then 1. HWRST_WAIT then lasts HWRST_WAIT_CYC cycles before ISSUE of step 0.
- Undefined: the HWRST states are not compiled; lcd_rst_n is constant 1. The port is always present.

Decomposition:
- Package lcd_pkg:
  - state encodings (3-bit localparams);
  - command index constants CMD_SWRESET=0, CMD_SLPOUT=1, CMD_RAMWR=8;
  - default wait constants.
- One natural sub-module: lcd_wait_timer. It is a loadable 24-bit down-counter with load/expired, shared by the HWRST, GAP and timeout waits.

Test Plan:
- Use small parameters for directed tests: NUM_STEPS=3, RESET_WAIT_CYC=20, SLPOUT_WAIT_CYC=10, STEP_WAIT_CYC=4, TIMEOUT_CYC=50, macro off.
- Normal run:
  - Stimulus: start pulse; executor model returns cmd_done 5 cycles after each cmd_start.
  - Required response: cmd_start pulses with cmd_num 0,1,2. The next cmd_start follows the previous cmd_done by 20 cycles, then 10 cycles. seq_done=pixel_grant=1 one cycle after the 3rd cmd_done; busy falls in the same cycle.
- Timeout:
  - Stimulus: suppress cmd_done for step 1.
  - Required response: seq_error=1 exactly 50 cycles after the step-1 cmd_start; cmd_num=1; pixel_grant=0; no further cmd_start.
- Collision: cmd_done in the same cycle as timeout expiry -> no error; sequence advances to GAP.
- Spurious inputs: cmd_done during GAP and a start while busy -> both ignored; step ordering and count of 3 cmd_start pulses unchanged.
- Reset mid-GAP: assert rst_n=0 during step-0 gap -> all outputs return to reset values asynchronously. A later start reissues cmd_num=0.
- LCD_HW_RESET_EN with HWRST_LOW_CYC=8, HWRST_WAIT_CYC=12:
  - Stimulus: start pulse.
  - Required response: lcd_rst_n low for 8 cycles; first cmd_start 12 cycles after release.
